// File: rtl/seq_shift_unit.sv
// Multi-cycle shift engine: moves the operand one bit position per clock between two valid/ready handshakes.
// Define SEQ_SHIFT_UNIT_ROTATE_EN to honour up_rot (rotate); otherwise up_rot is ignored.
module seq_shift_unit #(
   parameter int N  = 8,
   parameter int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [N-1:0]  up_data,
   input  logic [SW-1:0] up_amount,
   input  logic          up_dir,
   input  logic          up_arith,
   input  logic          up_rot,
   output logic          down_valid,
   input  logic          down_ready,
   output logic [N-1:0]  down_data
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t        state, state_nxt;
   logic [N-1:0]  work, work_shifted;
   logic [SW-1:0] cnt;
   logic          dir_q, arith_q;
   logic          fill_lsb, fill_msb;
   logic          accept;

   assign up_ready   = (state == IDLE);
   assign down_valid = (state == DONE);
   assign accept     = up_valid && (state == IDLE);

`ifdef SEQ_SHIFT_UNIT_ROTATE_EN
   logic rot_q;

   assign fill_lsb = rot_q ? work[N-1] : 1'b0;
   assign fill_msb = rot_q ? work[0] : (arith_q ? work[N-1] : 1'b0);
`else
   logic unused_rot;

   assign unused_rot = up_rot;
   assign fill_lsb   = 1'b0;
   assign fill_msb   = arith_q ? work[N-1] : 1'b0;
`endif

   // One-bit step in the captured direction; a single shifter is reused every SHIFT cycle.
   assign work_shifted = dir_q ? {fill_msb, work[N-1:1]} : {work[N-2:0], fill_lsb};

   // NOTE: every always_comb output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (up_valid) state_nxt = (up_amount == '0) ? DONE : SHIFT;
         SHIFT:   if (cnt == SW'(1)) state_nxt = DONE;
         DONE:    if (down_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         work      <= '0;
         cnt       <= '0;
         dir_q     <= 1'b0;
         arith_q   <= 1'b0;
         down_data <= '0;
`ifdef SEQ_SHIFT_UNIT_ROTATE_EN
         rot_q     <= 1'b0;
`endif
      end else begin
         if (accept) begin
            work    <= up_data;
            cnt     <= up_amount;
            dir_q   <= up_dir;
            arith_q <= up_arith;
`ifdef SEQ_SHIFT_UNIT_ROTATE_EN
            rot_q   <= up_rot;
`endif
            if (up_amount == '0) down_data <= up_data;
         end else if (state == SHIFT) begin
            work <= work_shifted;
            cnt  <= cnt - SW'(1);
            // down_data only moves when the final step lands, so it holds through DONE and after the handshake.
            if (cnt == SW'(1)) down_data <= work_shifted;
         end
      end
   end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed cases plus random operations against operator-based reference.
module tb_seq_shift_unit;

   localparam int N  = 8;
   localparam int SW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          up_valid;
   logic          up_ready;
   logic [N-1:0]  up_data;
   logic [SW-1:0] up_amount;
   logic          up_dir;
   logic          up_arith;
   logic          up_rot;
   logic          down_valid;
   logic          down_ready;
   logic [N-1:0]  down_data;

   int checks = 0;
   int errors = 0;

   seq_shift_unit #(.N(N), .SW(SW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .up_amount  (up_amount),
      .up_dir     (up_dir),
      .up_arith   (up_arith),
      .up_rot     (up_rot),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: the combinational shift/rotate operators applied to the whole operand at once.
   function automatic logic [N-1:0] model(input logic [N-1:0] d, input int a,
                                          input logic dir, input logic arith, input logic rot);
      logic [2*N-1:0] dd;
      dd = {d, d};
`ifdef SEQ_SHIFT_UNIT_ROTATE_EN
      if (rot) begin
         if (dir) return N'(dd >> a);
         else     return N'((dd << a) >> N);
      end
`else
      if (rot) begin end
`endif
      if (!dir)      return d << a;
      else if (arith) return N'($signed(d) >>> a);
      else           return d >> a;
   endfunction

   // One full transaction: accept, measure latency, optional backpressure hold, handshake.
   task automatic do_op(input string tag, input logic [N-1:0] d, input int a, input logic dir,
                        input logic arith, input logic rot, input int hold, input logic busy);
      logic [N-1:0] exp;
      int cycles;
      exp = model(d, a, dir, arith, rot);
      @(negedge clk);
      up_valid  = 1'b1;
      up_data   = d;
      up_amount = SW'(a);
      up_dir    = dir;
      up_arith  = arith;
      up_rot    = rot;
      check({tag, " ready_idle"}, 32'(up_ready), 32'd1);
      @(negedge clk);
      if (busy) begin
         up_data  = ~d;
         up_dir   = ~dir;
         up_arith = ~arith;
      end else begin
         up_valid = 1'b0;
      end
      cycles = 1;
      while (!down_valid && cycles < N + 4) begin
         if (busy) check({tag, " busy_ready"}, 32'(up_ready), 32'd0);
         @(negedge clk);
         cycles++;
      end
      check({tag, " latency"}, 32'(cycles), 32'(a + 1));
      check({tag, " data"}, 32'(down_data), 32'(exp));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, " hold_valid"}, 32'(down_valid), 32'd1);
         check({tag, " hold_data"}, 32'(down_data), 32'(exp));
         check({tag, " hold_ready"}, 32'(up_ready), 32'd0);
      end
      down_ready = 1'b1;
      @(negedge clk);
      down_ready = 1'b0;
      up_valid   = 1'b0;
      check({tag, " post_valid"}, 32'(down_valid), 32'd0);
      check({tag, " post_data"}, 32'(down_data), 32'(exp));
      check({tag, " post_ready"}, 32'(up_ready), 32'd1);
   endtask

   initial begin
      rst_n      = 1'b0;
      up_valid   = 1'b0;
      up_data    = '0;
      up_amount  = '0;
      up_dir     = 1'b0;
      up_arith   = 1'b0;
      up_rot     = 1'b0;
      down_ready = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("reset up_ready", 32'(up_ready), 32'd1);
      check("reset down_valid", 32'(down_valid), 32'd0);
      check("reset down_data", 32'(down_data), 32'h00);

      do_op("left3",    8'b1011_0011, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      do_op("lsr3",     8'b1011_0011, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      do_op("asr3",     8'b1011_0011, 3, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      do_op("amt0",     8'hA5,        0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      do_op("left7",    8'h01,        7, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      do_op("backpres", 8'h6C,        2, 1'b1, 1'b1, 1'b0, 5, 1'b1);
`ifdef SEQ_SHIFT_UNIT_ROTATE_EN
      do_op("rotr1",    8'b1000_0001, 1, 1'b1, 1'b1, 1'b1, 0, 1'b0);
      do_op("rotl3",    8'b1011_0011, 3, 1'b0, 1'b0, 1'b1, 0, 1'b0);
`else
      do_op("rot_ign",  8'b1000_0001, 1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
`endif

      // Reset during SHIFT: amount 6, reset lands on the third edge after accept.
      @(negedge clk);
      up_valid  = 1'b1;
      up_data   = 8'hF0;
      up_amount = SW'(6);
      up_dir    = 1'b0;
      @(negedge clk);
      up_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst up_ready", 32'(up_ready), 32'd1);
      check("midrst down_valid", 32'(down_valid), 32'd0);
      check("midrst down_data", 32'(down_data), 32'h00);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("midrst no_valid", 32'(down_valid), 32'd0);
      end

      for (int i = 0; i < 1000; i++) begin
         do_op("random", N'($urandom), int'($urandom_range(N - 1, 0)), 1'($urandom),
               1'($urandom), 1'($urandom), int'($urandom_range(2, 0)), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
